// File: rtl/de_arbiter.sv
// de_arbiter
//   Shares one frame-store memory port between two drawing-side requesters,
//   A and B. Grants alternate round-robin; a requester holding lock keeps
//   the grant across acks for up to MAX_BURST transfers, then is forced
//   back through IDLE so the other side gets a turn.
//
// Ports
//   clk, nreset              clock (rising edge) and async active-low reset
//   a_*/b_* req,lock         request / burst lock from each requester
//   a_*/b_* addr,nbyte,rnw,  transfer fields, held stable until ack
//           w_data
//   a_*/b_* ack, r_data      completion pulse and read data to requesters
//   mem_req/addr/nbyte/rnw/  muxed request toward memory (idle values when
//   mem_w_data               no grant: 0 / 0 / 4'b1111 / 1 / 0)
//   mem_ack, mem_r_data      memory completion pulse and read data
module de_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        nreset,

    input  logic        a_req,
    input  logic        a_lock,
    output logic        a_ack,
    input  logic [17:0] a_addr,
    input  logic [3:0]  a_nbyte,
    input  logic        a_rnw,
    input  logic [31:0] a_w_data,
    output logic [31:0] a_r_data,

    input  logic        b_req,
    input  logic        b_lock,
    output logic        b_ack,
    input  logic [17:0] b_addr,
    input  logic [3:0]  b_nbyte,
    input  logic        b_rnw,
    input  logic [31:0] b_w_data,
    output logic [31:0] b_r_data,

    output logic        mem_req,
    input  logic        mem_ack,
    output logic [17:0] mem_addr,
    output logic [3:0]  mem_nbyte,
    output logic        mem_rnw,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;

    localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

    logic [1:0] state;
    logic       rr_ptr;     // 0 = A has priority on a tie, 1 = B
    logic [7:0] burst_cnt;

    logic       gnt_a;
    logic       gnt_b;
    logic [8:0] burst_next;

    assign gnt_a      = (state == GNT_A);
    assign gnt_b      = (state == GNT_B);
    assign burst_next = {1'b0, burst_cnt} + 9'd1;

    // Outputs are purely combinational from state, so an asynchronous reset
    // drops mem_req and both acks immediately.
    always_comb begin
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_nbyte  = '1;
        mem_rnw    = 1'b1;
        mem_w_data = '0;
        a_ack      = 1'b0;
        b_ack      = 1'b0;
        a_r_data   = '0;
        b_r_data   = '0;
        if (gnt_a) begin
            mem_req    = a_req;
            mem_addr   = a_addr;
            mem_nbyte  = a_nbyte;
            mem_rnw    = a_rnw;
            mem_w_data = a_w_data;
            a_ack      = mem_ack;
            a_r_data   = mem_r_data;
        end else if (gnt_b) begin
            mem_req    = b_req;
            mem_addr   = b_addr;
            mem_nbyte  = b_nbyte;
            mem_rnw    = b_rnw;
            mem_w_data = b_w_data;
            b_ack      = mem_ack;
            b_r_data   = mem_r_data;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // mem_ack here is spurious and deliberately ignored
                    if (a_req && (!b_req || !rr_ptr)) begin
                        state     <= GNT_A;
                        burst_cnt <= '0;
                    end else if (b_req) begin
                        state     <= GNT_B;
                        burst_cnt <= '0;
                    end
                end
                GNT_A: begin
                    if (mem_ack) begin
                        if (burst_cnt != 8'hFF)
                            burst_cnt <= burst_cnt + 8'd1;
                        if (!(a_lock && (burst_next < BURST_LIMIT))) begin
                            state  <= IDLE;
                            rr_ptr <= 1'b1;
                        end
                    end else if (!a_req) begin
                        state  <= IDLE;
                        rr_ptr <= 1'b1;
                    end
                end
                GNT_B: begin
                    if (mem_ack) begin
                        if (burst_cnt != 8'hFF)
                            burst_cnt <= burst_cnt + 8'd1;
                        if (!(b_lock && (burst_next < BURST_LIMIT))) begin
                            state  <= IDLE;
                            rr_ptr <= 1'b0;
                        end
                    end else if (!b_req) begin
                        state  <= IDLE;
                        rr_ptr <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_de_arbiter.sv
// tb_de_arbiter
//   Directed bench for de_arbiter (MAX_BURST = 8). Inputs change on the
//   falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_de_arbiter;

    logic        clk;
    logic        nreset;
    logic        a_req, a_lock, a_ack, a_rnw;
    logic [17:0] a_addr;
    logic [3:0]  a_nbyte;
    logic [31:0] a_w_data, a_r_data;
    logic        b_req, b_lock, b_ack, b_rnw;
    logic [17:0] b_addr;
    logic [3:0]  b_nbyte;
    logic [31:0] b_w_data, b_r_data;
    logic        mem_req, mem_ack, mem_rnw;
    logic [17:0] mem_addr;
    logic [3:0]  mem_nbyte;
    logic [31:0] mem_w_data, mem_r_data;

    int tests;
    int failed;

    de_arbiter #(.MAX_BURST(8)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .a_req      (a_req),
        .a_lock     (a_lock),
        .a_ack      (a_ack),
        .a_addr     (a_addr),
        .a_nbyte    (a_nbyte),
        .a_rnw      (a_rnw),
        .a_w_data   (a_w_data),
        .a_r_data   (a_r_data),
        .b_req      (b_req),
        .b_lock     (b_lock),
        .b_ack      (b_ack),
        .b_addr     (b_addr),
        .b_nbyte    (b_nbyte),
        .b_rnw      (b_rnw),
        .b_w_data   (b_w_data),
        .b_r_data   (b_r_data),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_nbyte  (mem_nbyte),
        .mem_rnw    (mem_rnw),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"},   64'(mem_req),    64'h0);
        chk({tag, "_nbyte"}, 64'(mem_nbyte),  64'hF);
        chk({tag, "_rnw"},   64'(mem_rnw),    64'h1);
        chk({tag, "_addr"},  64'(mem_addr),   64'h0);
        chk({tag, "_wdata"}, 64'(mem_w_data), 64'h0);
        chk({tag, "_aack"},  64'(a_ack),      64'h0);
        chk({tag, "_back"},  64'(b_ack),      64'h0);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        nreset = 1'b0;
        a_req = 0; a_lock = 0; a_addr = '0; a_nbyte = '1; a_rnw = 1; a_w_data = '0;
        b_req = 0; b_lock = 0; b_addr = '0; b_nbyte = '1; b_rnw = 1; b_w_data = '0;
        mem_ack = 0; mem_r_data = '0;

        // ---- reset state
        @(negedge clk); #1;
        chk_idle("rst");
        @(negedge clk);
        nreset = 1'b1;

        // ---- A alone, single write
        @(negedge clk);
        a_req = 1; a_addr = 18'h00123; a_rnw = 0; a_w_data = 32'hDEADBEEF; a_nbyte = 4'b0000;
        #1 chk("t1_bubble_req", 64'(mem_req), 64'h0);
        @(negedge clk); #1;
        chk("t1_req",   64'(mem_req),    64'h1);
        chk("t1_addr",  64'(mem_addr),   64'h00123);
        chk("t1_nbyte", 64'(mem_nbyte),  64'h0);
        chk("t1_rnw",   64'(mem_rnw),    64'h0);
        chk("t1_wdata", 64'(mem_w_data), 64'hDEADBEEF);
        chk("t1_wait_aack", 64'(a_ack),  64'h0);
        @(negedge clk);
        mem_ack = 1;
        #1 chk("t1_aack", 64'(a_ack), 64'h1);
        chk("t1_back", 64'(b_ack), 64'h0);
        @(negedge clk);
        mem_ack = 0; a_req = 0;
        #1 chk_idle("t1_after");

        // restore rr_ptr = A for the alternation test
        nreset = 0;
        @(negedge clk);
        nreset = 1;

        // ---- A and B together, unlocked, 4 transfers each
        a_addr = 18'h0AAAA; a_rnw = 0; a_nbyte = 4'b0011; a_w_data = 32'h11111111;
        b_addr = 18'h0BBBB; b_rnw = 0; b_nbyte = 4'b1100; b_w_data = 32'h22222222;
        @(negedge clk);
        a_req = 1; b_req = 1;
        #1 chk("t2_start_req", 64'(mem_req), 64'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk($sformatf("t2_req%0d", i), 64'(mem_req), 64'h1);
            chk($sformatf("t2_addr%0d", i), 64'(mem_addr),
                (i % 2 == 0) ? 64'h0AAAA : 64'h0BBBB);
            mem_ack = 1;
            #1;
            chk($sformatf("t2_aack%0d", i), 64'(a_ack), (i % 2 == 0) ? 64'h1 : 64'h0);
            chk($sformatf("t2_back%0d", i), 64'(b_ack), (i % 2 == 0) ? 64'h0 : 64'h1);
            @(negedge clk);
            mem_ack = 0;
            if (i == 7) begin
                a_req = 0; b_req = 0;
            end
            #1;
            chk($sformatf("t2_gap_req%0d", i), 64'(mem_req), 64'h0);
            chk($sformatf("t2_gap_ack%0d", i), 64'({a_ack, b_ack}), 64'h0);
        end

        // ---- A locked burst, B waiting (rr_ptr = A after last B grant)
        b_rnw = 1; b_addr = 18'h3FFFF;
        @(negedge clk);
        a_req = 1; a_lock = 1; b_req = 1;
        mem_r_data = 32'h12345678;
        #1 chk("t3_start_req", 64'(mem_req), 64'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_ack = 1;
            #1;
            chk($sformatf("t3_req%0d", i),   64'(mem_req),  64'h1);
            chk($sformatf("t3_aack%0d", i),  64'(a_ack),    64'h1);
            chk($sformatf("t3_back%0d", i),  64'(b_ack),    64'h0);
            chk($sformatf("t3_ardat%0d", i), 64'(a_r_data), 64'h12345678);
            chk($sformatf("t3_brdat%0d", i), 64'(b_r_data), 64'h0);
        end
        @(negedge clk);
        mem_ack = 0;
        #1;
        // A still requesting with lock, yet the grant must have been released
        chk("t3_forced_release", 64'(mem_req), 64'h0);
        chk("t3_release_ack", 64'({a_ack, b_ack}), 64'h0);
        a_req = 0; a_lock = 0;
        @(negedge clk); #1;
        chk("t3_b_req",  64'(mem_req),  64'h1);
        chk("t3_b_addr", 64'(mem_addr), 64'h3FFFF);
        chk("t3_b_rnw",  64'(mem_rnw),  64'h1);
        mem_r_data = 32'h0BADF00D;
        mem_ack = 1;
        #1;
        chk("t3_back",  64'(b_ack),    64'h1);
        chk("t3_aack",  64'(a_ack),    64'h0);
        chk("t3_brdat", 64'(b_r_data), 64'h0BADF00D);
        chk("t3_ardat", 64'(a_r_data), 64'h0);
        @(negedge clk);
        mem_ack = 0; b_req = 0; mem_r_data = '0;

        // ---- spurious mem_ack in IDLE, then A drops req mid-grant
        @(negedge clk);
        mem_ack = 1;
        #1 chk("t4_spur_ack", 64'({a_ack, b_ack}), 64'h0);
        chk("t4_spur_req", 64'(mem_req), 64'h0);
        @(negedge clk);
        mem_ack = 0; a_req = 1;
        @(negedge clk); #1;
        chk("t4_gnt_req", 64'(mem_req), 64'h1);
        a_req = 0;
        #1 chk("t4_drop_req", 64'(mem_req), 64'h0);
        chk("t4_drop_ack", 64'({a_ack, b_ack}), 64'h0);
        @(negedge clk);
        a_req = 1; b_req = 1;
        #1 chk("t4_idle_req", 64'(mem_req), 64'h0);
        @(negedge clk); #1;
        // rr_ptr moved to B after the abandoned A grant
        chk("t4_rr_b_req",  64'(mem_req),  64'h1);
        chk("t4_rr_b_addr", 64'(mem_addr), 64'h3FFFF);

        // ---- asynchronous reset while GNT_B waits
        #2 nreset = 0;
        mem_ack = 1;
        #1;
        chk("t5_rst_req",  64'(mem_req),  64'h0);
        chk("t5_rst_ack",  64'({a_ack, b_ack}), 64'h0);
        chk("t5_rst_addr", 64'(mem_addr), 64'h0);
        mem_ack = 0;
        @(negedge clk);
        nreset = 1;
        @(negedge clk); #1;
        chk("t5_after_req",  64'(mem_req),  64'h1);
        chk("t5_after_addr", 64'(mem_addr), 64'h0AAAA);
        mem_ack = 1;
        #1 chk("t5_after_aack", 64'(a_ack), 64'h1);
        chk("t5_after_back", 64'(b_ack), 64'h0);
        @(negedge clk);
        mem_ack = 0; a_req = 0; b_req = 0;
        @(negedge clk); #1;
        chk_idle("end");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
